axis_step_gen: RTL and testbench
================================

# axis_step_gen

Per-axis step/direction pulse generator that sits directly downstream of `calc_times`. It latches one move: phase step counts and step-interval ramp parameters for a single axis. It then drives the stepper driver's STEP/DIR pins with a trapezoidal interval profile in three phases: acceleration, cruise, deceleration. The top level instantiates one copy per axis (X, Y, Z, E0, E1) and starts all copies together when `calc_times` asserts `finish`.

## Interface
- `PULSE_WIDTH`, default 10: STEP high time in clock cycles; legal range is 1 or more.
- `clk`, input, 1 bit: system clock; all state changes on the rising edge.
- `reset`, input, 1 bit: asynchronous, active-low reset.
- `start`, input, 1 bit: move request; sampled only in IDLE.
- `dir_in`, input, 1 bit: move direction; latched on start acceptance.
- `n_acc`, input, 32 bits: number of acceleration-phase steps.
- `n_cruise`, input, 32 bits: number of cruise-phase steps.
- `n_dec`, input, 32 bits: number of deceleration-phase steps.
- `period_start`, input, 32 bits: interval of the first step, in clock cycles.
- `period_min`, input, 32 bits: floor on the interval during acceleration.
- `period_delta`, input, 32 bits: amount the interval changes per step during ramps.
- `step`, output, 1 bit: STEP pin.
- `dir`, output, 1 bit: DIR pin; holds the latched `dir_in`.
- `busy`, output, 1 bit: high while a move is in progress.
- `done`, output, 1 bit: one-cycle pulse at the end of a move.
- `steps_done`, output, 32 bits: count of STEP rising edges in the current or most recent move.

## Operation
- States: IDLE → ACCEL → CRUISE → DECEL → IDLE. Phases with a zero count are skipped.
- Start acceptance (IDLE, `start`=1 at edge k):
  - All inputs are latched.
  - `dir` ← `dir_in`, `busy` ← 1, `steps_done` ← 0, `cur` ← `period_start`.
  - Next state is the first phase with a nonzero count, checked in order ACCEL, CRUISE, DECEL.
  - If all counts are 0: the block stays IDLE, `busy` stays 0, and `done` pulses for the cycle after edge k. No STEP is issued.
- `start` while busy is ignored and has no side effects. Input changes after acceptance have no effect on the move.
- Interval used by each step:
  - ACCEL step: interval = `cur`. Afterwards, if `cur` < `period_min` + `period_delta` (33-bit compare), `cur` ← `period_min`; otherwise `cur` ← `cur` − `period_delta`.
  - CRUISE step: interval = `cur`, unchanged.
  - DECEL step: before the step, `cur` ← `cur` + `period_delta`, saturating at 32'hFFFFFFFF; interval = the updated `cur`.
  - Effective interval = max(interval, `PULSE_WIDTH`+1).
- Each step:
  - `step` rises, and `steps_done` increments on the same edge.
  - `step` stays high for `PULSE_WIDTH` cycles, then low for the rest of the effective interval.
  - The next step (or completion) occurs exactly one effective interval after the previous rise.
- Completion: one effective interval after the last STEP rise:
  - `done` = 1 for one cycle, `busy` ← 0, state ← IDLE.
  - `steps_done` and `dir` hold their values until the next accepted start.
- `start` sampled high in the same cycle `done` is high (IDLE reached) is accepted normally.

## Timing
- Reset values: `step`=0, `dir`=0, `busy`=0, `done`=0, `steps_done`=0, state IDLE, `cur`=0.
- Asserting `reset` mid-move aborts immediately, asynchronously, to these values. `step` must never stay high.
- Start latency: `busy`=1 and `dir` valid after edge k. First STEP rise at edge k+1, giving one cycle of DIR setup before STEP.
- Move duration: `done` asserts at edge k+1+Σ(effective intervals).
- Phase transitions add no extra cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- Counters are 32-bit. The interval counter reloads on each STEP rise.

## Test plan
- Trapezoid profile:
  - Stimulus: `PULSE_WIDTH`=10, `n_acc`=3, `n_cruise`=2, `n_dec`=2, `period_start`=100, `period_min`=60, `period_delta`=20.
  - Required: STEP rises at k+1, 101, 181, 241, 301, 361, 441.
  - Required: `done` at k+541, `steps_done`=7, each high pulse lasts 10 cycles.
- Zero move:
  - Stimulus: all counts 0.
  - Required: no STEP, `busy` stays 0, `done` pulses once after edge k, `steps_done`=0.
- Interval clamp:
  - Stimulus: `n_cruise`=3, `period_start`=5, `period_delta`=0.
  - Required: STEP rises at k+1, 12, 23; `done` at k+34.
- Ramp limits:
  - Accel stimulus: `period_start`=10, `period_min`=15, `period_delta`=50, `n_acc`=2. Required: intervals 11 then 15.
  - Decel stimulus: `period_start`=32'hFFFFFFF0, `period_delta`=32, `n_dec`=1. Required: interval 32'hFFFFFFFF, with no wraparound.
- Ignored inputs during a move:
  - Stimulus: `start` pulsed mid-move, and `dir_in` toggled mid-move.
  - Required: the profile is unchanged, `dir` is unchanged, and only one `done` is issued.
- Reset mid-move:
  - Stimulus: `reset` asserted low while `step`=1 during case 1.
  - Required: all outputs go to 0 without waiting for a clock edge.
  - Required: after release, a new start executes the full case-1 profile.

Source files
------------

// File: rtl/axis_step_gen_if.sv
// Move-request and step/direction bundle between the move planner and one axis generator.
interface axis_step_gen_if;
    logic        start;
    logic        dir_in;
    logic [31:0] n_acc;
    logic [31:0] n_cruise;
    logic [31:0] n_dec;
    logic [31:0] period_start;
    logic [31:0] period_min;
    logic [31:0] period_delta;
    logic        step;
    logic        dir;
    logic        busy;
    logic        done;
    logic [31:0] steps_done;

    // Planner side: issues the move and watches the pins.
    modport master (
        output start, dir_in, n_acc, n_cruise, n_dec,
               period_start, period_min, period_delta,
        input  step, dir, busy, done, steps_done
    );

    // Generator side: accepts the move and drives the pins.
    modport slave (
        input  start, dir_in, n_acc, n_cruise, n_dec,
               period_start, period_min, period_delta,
        output step, dir, busy, done, steps_done
    );
endinterface

// File: rtl/axis_step_gen.sv
// Single-axis STEP/DIR generator producing an accelerate/cruise/decelerate
// interval profile. One move is latched on start and then runs to completion.
module axis_step_gen #(
    parameter int PULSE_WIDTH = 10
) (
    input  logic            clk,
    input  logic            reset,
    axis_step_gen_if.slave  bus
);

    // Shortest interval that still leaves a low phase after the STEP pulse.
    localparam logic [31:0] MIN_EFF  = 32'(PULSE_WIDTH + 1);
    localparam logic [31:0] HIGH_CNT = 32'(PULSE_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEL  = 2'd1,
        CRUISE = 2'd2,
        DECEL  = 2'd3
    } state_t;

    state_t      state, state_next;

    // cnt is the number of steps still to issue in the current phase; when it
    // reaches zero the phase only waits out the last interval and then finishes.
    logic [31:0] cur, cur_next;
    logic [31:0] cnt, cnt_next;
    logic [31:0] timer, timer_next;
    logic [31:0] pulse_cnt, pulse_next;
    logic [31:0] cruise_q, cruise_next;
    logic [31:0] dec_q, dec_next;
    logic [31:0] min_q, min_next;
    logic [31:0] delta_q, delta_next;
    logic [31:0] steps_q, steps_next;
    logic        step_q, step_next;
    logic        dir_q, dir_next;
    logic        busy_q, busy_next;
    logic        done_q, done_next;

    logic [32:0] accel_floor;
    logic [31:0] accel_cur;
    logic [32:0] decel_sum;
    logic [31:0] decel_cur;
    logic [31:0] step_interval;
    logic [31:0] eff_interval;

    // Ramp arithmetic: the accel floor compare is done in 33 bits so that a
    // large min+delta cannot wrap, and the decel add saturates at all-ones.
    always_comb begin
        accel_floor   = {1'b0, min_q} + {1'b0, delta_q};
        accel_cur     = ({1'b0, cur} < accel_floor) ? min_q : (cur - delta_q);
        decel_sum     = {1'b0, cur} + {1'b0, delta_q};
        decel_cur     = decel_sum[32] ? 32'hFFFF_FFFF : decel_sum[31:0];
        step_interval = (state == DECEL) ? decel_cur : cur;
        eff_interval  = (step_interval < MIN_EFF) ? MIN_EFF : step_interval;
    end

    // Next-state and next-output logic: start acceptance in IDLE, step
    // issue and phase hand-off when the interval timer expires elsewhere.
    always_comb begin
        state_next  = state;
        cur_next    = cur;
        cnt_next    = cnt;
        timer_next  = timer;
        pulse_next  = pulse_cnt;
        cruise_next = cruise_q;
        dec_next    = dec_q;
        min_next    = min_q;
        delta_next  = delta_q;
        steps_next  = steps_q;
        step_next   = step_q;
        dir_next    = dir_q;
        busy_next   = busy_q;
        done_next   = 1'b0;

        if (step_q) begin
            if (pulse_cnt == 32'd0) begin
                step_next = 1'b0;
            end else begin
                pulse_next = pulse_cnt - 32'd1;
            end
        end

        case (state)
            IDLE: begin
                if (bus.start) begin
                    dir_next    = bus.dir_in;
                    steps_next  = 32'd0;
                    cur_next    = bus.period_start;
                    cruise_next = bus.n_cruise;
                    dec_next    = bus.n_dec;
                    min_next    = bus.period_min;
                    delta_next  = bus.period_delta;
                    timer_next  = 32'd0;
                    if (bus.n_acc != 32'd0) begin
                        state_next = ACCEL;
                        cnt_next   = bus.n_acc;
                        busy_next  = 1'b1;
                    end else if (bus.n_cruise != 32'd0) begin
                        state_next = CRUISE;
                        cnt_next   = bus.n_cruise;
                        busy_next  = 1'b1;
                    end else if (bus.n_dec != 32'd0) begin
                        state_next = DECEL;
                        cnt_next   = bus.n_dec;
                        busy_next  = 1'b1;
                    end else begin
                        cnt_next  = 32'd0;
                        done_next = 1'b1;
                    end
                end
            end
            default: begin
                if (timer != 32'd0) begin
                    timer_next = timer - 32'd1;
                end else if (cnt == 32'd0) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    step_next  = 1'b1;
                    pulse_next = HIGH_CNT;
                    steps_next = steps_q + 32'd1;
                    timer_next = eff_interval - 32'd1;
                    if (state == ACCEL) begin
                        cur_next = accel_cur;
                    end else if (state == DECEL) begin
                        cur_next = decel_cur;
                    end
                    // The last step of a phase hands straight over to the
                    // next non-empty phase so no cycle is lost in between.
                    if (cnt == 32'd1) begin
                        cnt_next = 32'd0;
                        if (state == ACCEL && cruise_q != 32'd0) begin
                            state_next = CRUISE;
                            cnt_next   = cruise_q;
                        end else if (state != DECEL && dec_q != 32'd0) begin
                            state_next = DECEL;
                            cnt_next   = dec_q;
                        end
                    end else begin
                        cnt_next = cnt - 32'd1;
                    end
                end
            end
        endcase
    end

    // State and datapath registers; reset clears everything so STEP drops at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cur       <= 32'd0;
            cnt       <= 32'd0;
            timer     <= 32'd0;
            pulse_cnt <= 32'd0;
            cruise_q  <= 32'd0;
            dec_q     <= 32'd0;
            min_q     <= 32'd0;
            delta_q   <= 32'd0;
            steps_q   <= 32'd0;
            step_q    <= 1'b0;
            dir_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_next;
            cur       <= cur_next;
            cnt       <= cnt_next;
            timer     <= timer_next;
            pulse_cnt <= pulse_next;
            cruise_q  <= cruise_next;
            dec_q     <= dec_next;
            min_q     <= min_next;
            delta_q   <= delta_next;
            steps_q   <= steps_next;
            step_q    <= step_next;
            dir_q     <= dir_next;
            busy_q    <= busy_next;
            done_q    <= done_next;
        end
    end

    assign bus.step       = step_q;
    assign bus.dir        = dir_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.steps_done = steps_q;

endmodule

// File: tb/tb_axis_step_gen.sv
// Directed bench for axis_step_gen: trapezoid, zero move, interval clamp,
// ramp limits, ignored mid-move inputs and asynchronous abort.
module tb_axis_step_gen;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    int   k;

    axis_step_gen_if bus_if ();

    axis_step_gen #(.PULSE_WIDTH(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising-edge index used to time-stamp observed events.
    always @(posedge clk) cyc <= cyc + 1;

    int   rise_t[$];
    int   done_t[$];
    int   high_len[$];
    int   high_run;
    logic prev_step;

    // Records STEP rises, pulse lengths and done pulses away from the active edge.
    always @(negedge clk) begin
        if (bus_if.step && !prev_step) begin
            rise_t.push_back(cyc);
            high_run = 1;
        end else if (bus_if.step) begin
            high_run = high_run + 1;
        end else if (prev_step) begin
            high_len.push_back(high_run);
        end
        if (bus_if.done) done_t.push_back(cyc);
        prev_step = bus_if.step;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launches one move; returns with k holding the acceptance edge index.
    task automatic apply_stimulus(input logic d, input logic [31:0] na, input logic [31:0] nc,
                                  input logic [31:0] nd, input logic [31:0] ps,
                                  input logic [31:0] pm, input logic [31:0] pdl);
        @(posedge clk);
        #1;
        rise_t.delete();
        done_t.delete();
        high_len.delete();
        bus_if.dir_in       = d;
        bus_if.n_acc        = na;
        bus_if.n_cruise     = nc;
        bus_if.n_dec        = nd;
        bus_if.period_start = ps;
        bus_if.period_min   = pm;
        bus_if.period_delta = pdl;
        bus_if.start        = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        bus_if.start = 1'b0;
    endtask

    // Compares recorded rises (relative to k) and done times against a table.
    task automatic check_output(input string tag, input int exp_rise[], input int exp_done);
        check({tag, "_nrise"}, rise_t.size(), exp_rise.size());
        for (int i = 0; i < exp_rise.size() && i < rise_t.size(); i++)
            check($sformatf("%s_rise%0d", tag, i), rise_t[i] - k, exp_rise[i]);
        check({tag, "_ndone"}, done_t.size(), 1);
        if (done_t.size() > 0) check({tag, "_done_t"}, done_t[0] - k, exp_done);
    endtask

    int trap_rise[]  = '{1, 101, 181, 241, 301, 361, 441};
    int clamp_rise[] = '{1, 12, 23};
    int accel_rise[] = '{1, 12};
    int wait_n;

    initial begin
        cyc       = 0;
        checks    = 0;
        errors    = 0;
        prev_step = 1'b0;
        high_run  = 0;
        reset     = 1'b0;
        bus_if.start = 1'b0;  bus_if.dir_in = 1'b0;
        bus_if.n_acc = 0;     bus_if.n_cruise = 0;     bus_if.n_dec = 0;
        bus_if.period_start = 0; bus_if.period_min = 0; bus_if.period_delta = 0;

        // Reset values
        #1;
        check("rst_step", bus_if.step, 1'b0);
        check("rst_busy", bus_if.busy, 1'b0);
        check("rst_done", bus_if.done, 1'b0);
        check("rst_dir", bus_if.dir, 1'b0);
        check("rst_steps", bus_if.steps_done, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Trapezoid profile
        apply_stimulus(1'b1, 3, 2, 2, 100, 60, 20);
        @(negedge clk);
        check("trap_busy0", bus_if.busy, 1'b1);
        check("trap_dir0", bus_if.dir, 1'b1);
        check("trap_steps0", bus_if.steps_done, 32'd0);
        repeat (550) @(negedge clk);
        check_output("trap", trap_rise, 541);
        check("trap_steps", bus_if.steps_done, 32'd7);
        check("trap_busy", bus_if.busy, 1'b0);
        check("trap_dir", bus_if.dir, 1'b1);
        check("trap_npulse", high_len.size(), 7);
        for (int i = 0; i < high_len.size(); i++)
            check($sformatf("trap_width%0d", i), high_len[i], 10);

        // Zero move
        apply_stimulus(1'b0, 0, 0, 0, 100, 60, 20);
        @(negedge clk);
        check("zero_done", bus_if.done, 1'b1);
        check("zero_busy", bus_if.busy, 1'b0);
        check("zero_steps", bus_if.steps_done, 32'd0);
        check("zero_dir", bus_if.dir, 1'b0);
        repeat (5) @(negedge clk);
        check("zero_nrise", rise_t.size(), 0);
        check("zero_ndone", done_t.size(), 1);
        check("zero_busy_end", bus_if.busy, 1'b0);

        // Interval clamp to PULSE_WIDTH+1
        apply_stimulus(1'b1, 0, 3, 0, 5, 0, 0);
        repeat (40) @(negedge clk);
        check_output("clamp", clamp_rise, 34);
        check("clamp_steps", bus_if.steps_done, 32'd3);

        // Accel floor: intervals 11 then 15
        apply_stimulus(1'b0, 2, 0, 0, 10, 15, 50);
        repeat (35) @(negedge clk);
        check_output("accel", accel_rise, 27);

        // Decel saturation: next interval would wrap to 16 without saturation
        apply_stimulus(1'b1, 0, 0, 1, 32'hFFFF_FFF0, 0, 32);
        repeat (300) @(negedge clk);
        check("decel_nrise", rise_t.size(), 1);
        check("decel_ndone", done_t.size(), 0);
        check("decel_busy", bus_if.busy, 1'b1);
        check("decel_cur", dut.cur, 32'hFFFF_FFFF);
        #2 reset = 1'b0;
        #1;
        check("decel_abort_busy", bus_if.busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Mid-move start and dir_in changes are ignored
        apply_stimulus(1'b0, 3, 2, 2, 100, 60, 20);
        repeat (150) @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.dir_in = 1'b1;
        bus_if.n_acc = 1;
        bus_if.period_start = 7;
        repeat (2) @(negedge clk);
        bus_if.start = 1'b0;
        repeat (400) @(negedge clk);
        check_output("ign", trap_rise, 541);
        check("ign_dir", bus_if.dir, 1'b0);
        check("ign_steps", bus_if.steps_done, 32'd7);
        bus_if.dir_in = 1'b0;

        // Asynchronous reset while STEP is high
        apply_stimulus(1'b1, 3, 2, 2, 100, 60, 20);
        wait_n = 0;
        while (rise_t.size() < 2 && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        check("abort_found_step", bus_if.step, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("abort_step", bus_if.step, 1'b0);
        check("abort_busy", bus_if.busy, 1'b0);
        check("abort_dir", bus_if.dir, 1'b0);
        check("abort_done", bus_if.done, 1'b0);
        check("abort_steps", bus_if.steps_done, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        apply_stimulus(1'b1, 3, 2, 2, 100, 60, 20);
        repeat (550) @(negedge clk);
        check_output("rerun", trap_rise, 541);
        check("rerun_steps", bus_if.steps_done, 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
